// File: rtl/combat_pkg.sv
// combat_pkg
// Shared definitions for the combat referee: round state encoding, winner
// codes, default parameter values and two small arithmetic helpers used by
// the hit test and the health registers.
package combat_pkg;

    // Round state: waiting for a round, fighting, or results frozen.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    // Winner codes as seen by the game FSM and the display logic.
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Default tuning values.
    localparam logic [3:0] DEF_MAX_HEALTH = 4'd9;
    localparam logic [9:0] DEF_HIT_RANGE  = 10'd64;
    localparam logic [9:0] DEF_Y_TOL      = 10'd16;
    localparam int         DEF_COOLDOWN   = 25;

    // Distance between two screen coordinates, always larger minus smaller
    // so the unsigned subtraction never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Health decrement that sticks at zero.
    function automatic logic [3:0] dec_sat(input logic [3:0] h);
        return (h == 4'd0) ? 4'd0 : (h - 4'd1);
    endfunction

endpackage

// File: rtl/attack_channel.sv
// attack_channel
// One player's attack front end: remembers the previous attack level,
// detects rising edges, and runs a cooldown counter that blocks further
// edges for a fixed number of active cycles after an accepted one.
//
// Ports:
//   effective_clk  in   clock
//   reset          in   asynchronous, active-high
//   attack         in   raw attack level
//   clear          in   round restart: zero the cooldown, accept nothing
//   run            in   round active and not paused
//   accept         out  this edge counts as an attack (combinational)
module attack_channel
    import combat_pkg::*;
#(
    parameter int COOLDOWN = DEF_COOLDOWN
) (
    input  logic effective_clk,
    input  logic reset,
    input  logic attack,
    input  logic clear,
    input  logic run,
    output logic accept
);

    localparam int CW = $clog2(COOLDOWN + 1);

    logic          hist_q;
    logic          hist_d;
    logic [CW-1:0] cd_q;
    logic [CW-1:0] cd_d;

    // The history register always tracks the input, even when paused, so an
    // edge that happens while the fight is not running is lost rather than
    // replayed later.
    always_comb begin
        hist_d = attack;
        accept = attack & ~hist_q & run & ~clear & (cd_q == '0);
        cd_d   = cd_q;
        if (clear) begin
            cd_d = '0;
        end else if (accept) begin
            cd_d = CW'(COOLDOWN);
        end else if (run && cd_q != '0) begin
            cd_d = cd_q - CW'(1);
        end
    end

    always_ff @(posedge effective_clk or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b0;
            cd_q   <= '0;
        end else begin
            hist_q <= hist_d;
            cd_q   <= cd_d;
        end
    end

endmodule

// File: rtl/combat_referee.sv
// combat_referee
// Decides which attacks land between the two players, tracks both health
// values and declares the end of the round and its winner.
//
// Ports:
//   effective_clk             in   clock
//   reset                     in   asynchronous, active-high
//   round_start               in   one-cycle pulse, starts/restarts a round
//   enable                    in   fight running (low pauses)
//   p1_attack, p2_attack      in   raw attack levels
//   p1_posx .. p2_posy        in   10-bit player positions
//   p1_health, p2_health      out  current health
//   p1_hit, p2_hit            out  one-cycle pulse when that player is damaged
//   game_over                 out  high from the final hit to the next round
//   winner                    out  00 none, 01 p1, 10 p2, 11 draw
module combat_referee
    import combat_pkg::*;
#(
    parameter logic [3:0] MAX_HEALTH = DEF_MAX_HEALTH,
    parameter logic [9:0] HIT_RANGE  = DEF_HIT_RANGE,
    parameter logic [9:0] Y_TOL      = DEF_Y_TOL,
    parameter int         COOLDOWN   = DEF_COOLDOWN
) (
    input  logic       effective_clk,
    input  logic       reset,
    input  logic       round_start,
    input  logic       enable,
    input  logic       p1_attack,
    input  logic       p2_attack,
    input  logic [9:0] p1_posx,
    input  logic [9:0] p1_posy,
    input  logic [9:0] p2_posx,
    input  logic [9:0] p2_posy,
    output logic [3:0] p1_health,
    output logic [3:0] p2_health,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t     state_q, state_d;
    logic [3:0] p1_health_q, p1_health_d;
    logic [3:0] p2_health_q, p2_health_d;
    logic       p1_hit_q, p1_hit_d;
    logic       p2_hit_q, p2_hit_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;

    logic run;
    logic p1_accept;
    logic p2_accept;
    logic in_range;

    assign run = (state_q == ST_FIGHT) && enable;

    attack_channel #(
        .COOLDOWN(COOLDOWN)
    ) u_p1_channel (
        .effective_clk(effective_clk),
        .reset        (reset),
        .attack       (p1_attack),
        .clear        (round_start),
        .run          (run),
        .accept       (p1_accept)
    );

    attack_channel #(
        .COOLDOWN(COOLDOWN)
    ) u_p2_channel (
        .effective_clk(effective_clk),
        .reset        (reset),
        .attack       (p2_attack),
        .clear        (round_start),
        .run          (run),
        .accept       (p2_accept)
    );

    // Range is symmetric, so one comparator pair serves both attackers.
    assign in_range = (abs_diff(p1_posx, p2_posx) <= HIT_RANGE) &&
                      (abs_diff(p1_posy, p2_posy) <= Y_TOL);

    // Next-state and next-output logic. Both players' hits are applied on the
    // same edge, and the end-of-round test looks at the post-hit healths so
    // a simultaneous double knockout is reported as a draw.
    always_comb begin
        state_d     = state_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_hit_d    = 1'b0;
        p2_hit_d    = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (round_start) begin
            state_d     = ST_FIGHT;
            p1_health_d = MAX_HEALTH;
            p2_health_d = MAX_HEALTH;
            game_over_d = 1'b0;
            winner_d    = W_NONE;
        end else begin
            case (state_q)
                ST_FIGHT: begin
                    if (p1_accept && in_range) begin
                        p2_health_d = dec_sat(p2_health_q);
                        p2_hit_d    = 1'b1;
                    end
                    if (p2_accept && in_range) begin
                        p1_health_d = dec_sat(p1_health_q);
                        p1_hit_d    = 1'b1;
                    end
                    if (p1_health_d == 4'd0 || p2_health_d == 4'd0) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        if (p1_health_d == 4'd0 && p2_health_d == 4'd0) begin
                            winner_d = W_DRAW;
                        end else if (p2_health_d == 4'd0) begin
                            winner_d = W_P1;
                        end else begin
                            winner_d = W_P2;
                        end
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge effective_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            p1_health_q <= MAX_HEALTH;
            p2_health_q <= MAX_HEALTH;
            p1_hit_q    <= 1'b0;
            p2_hit_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= W_NONE;
        end else begin
            state_q     <= state_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_health = p1_health_q;
    assign p2_health = p2_health_q;
    assign p1_hit    = p1_hit_q;
    assign p2_hit    = p2_hit_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_combat_referee.sv
// tb_combat_referee
// Directed bench for the combat referee: hit, miss, cooldown boundaries,
// held attack, pause, final blow, round restart, draw and async reset.
module tb_combat_referee;

    logic       effective_clk = 1'b0;
    logic       reset;
    logic       round_start;
    logic       enable;
    logic       p1_attack;
    logic       p2_attack;
    logic [9:0] p1_posx;
    logic [9:0] p1_posy;
    logic [9:0] p2_posx;
    logic [9:0] p2_posy;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic       p1_hit;
    logic       p2_hit;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    combat_referee dut (
        .effective_clk(effective_clk),
        .reset        (reset),
        .round_start  (round_start),
        .enable       (enable),
        .p1_attack    (p1_attack),
        .p2_attack    (p2_attack),
        .p1_posx      (p1_posx),
        .p1_posy      (p1_posy),
        .p2_posx      (p2_posx),
        .p2_posy      (p2_posy),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 effective_clk = ~effective_clk;

    // Advance n rising edges and settle 1 ns after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge effective_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Full output snapshot against expected values.
    task automatic checkAll(input string tag, input logic [3:0] h1, input logic [3:0] h2,
                            input logic ht1, input logic ht2, input logic go,
                            input logic [1:0] w);
        checkOutput({tag, ".p1_health"}, 10'(p1_health), 10'(h1));
        checkOutput({tag, ".p2_health"}, 10'(p2_health), 10'(h2));
        checkOutput({tag, ".p1_hit"},    10'(p1_hit),    10'(ht1));
        checkOutput({tag, ".p2_hit"},    10'(p2_hit),    10'(ht2));
        checkOutput({tag, ".game_over"}, 10'(game_over), 10'(go));
        checkOutput({tag, ".winner"},    10'(winner),    10'(w));
    endtask

    initial begin
        reset       = 1'b1;
        round_start = 1'b0;
        enable      = 1'b0;
        p1_attack   = 1'b0;
        p2_attack   = 1'b0;
        p1_posx     = 10'd100;
        p1_posy     = 10'd200;
        p2_posx     = 10'd150;
        p2_posy     = 10'd205;
        applyStimulus(2);
        checkAll("reset", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        applyStimulus(1);

        // Start the round.
        enable      = 1'b1;
        round_start = 1'b1;
        applyStimulus(1);
        round_start = 1'b0;
        checkAll("start", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);

        // Basic hit, pulse exactly one cycle.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkAll("basic_hit", 4'd9, 4'd8, 1'b0, 1'b1, 1'b0, 2'b00);
        p1_attack = 1'b0;
        applyStimulus(1);
        checkOutput("basic_hit_pulse_end", 10'(p2_hit), 10'd0);
        applyStimulus(30);

        // Out of range by one pixel: miss, but cooldown starts (edge M).
        p2_posx   = 10'd165;
        p2_posy   = 10'd200;
        p1_attack = 1'b1;
        applyStimulus(1);
        checkAll("miss_dx65", 4'd9, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        p1_attack = 1'b0;
        p2_posx   = 10'd150;
        p2_posy   = 10'd205;
        applyStimulus(9);
        // Edge M+10 in range but during cooldown.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("cooldown_discard", 10'(p2_health), 10'd8);
        p1_attack = 1'b0;
        applyStimulus(15);
        // Edge M+26: first legal edge.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkAll("after_cooldown", 4'd9, 4'd7, 1'b0, 1'b1, 1'b0, 2'b00);
        p1_attack = 1'b0;
        applyStimulus(24);
        // Edge K+25: one cycle too early.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("cooldown_edge_early", 10'(p2_health), 10'd7);
        p1_attack = 1'b0;
        applyStimulus(1);
        // Held attack from edge K+27: exactly one hit over 100 cycles.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("held_first_hit", 10'(p2_health), 10'd6);
        applyStimulus(100);
        checkAll("held_100", 4'd9, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00);
        p1_attack = 1'b0;
        applyStimulus(1);

        // Pause mid-cooldown (accepted edge P, pause after P+4).
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("pause_setup_hit", 10'(p2_health), 10'd5);
        p1_attack = 1'b0;
        applyStimulus(4);
        enable = 1'b0;
        applyStimulus(20);
        p1_attack = 1'b1;
        applyStimulus(1);
        p1_attack = 1'b0;
        applyStimulus(29);
        checkOutput("pause_health_hold", 10'(p2_health), 10'd5);
        enable = 1'b1;
        applyStimulus(20);
        // Edge P+75: cooldown held at 21 during pause, still 1 here.
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("pause_cooldown_hold", 10'(p2_health), 10'd5);
        p1_attack = 1'b0;
        applyStimulus(1);
        p1_attack = 1'b1;
        applyStimulus(1);
        checkOutput("pause_resume_hit", 10'(p2_health), 10'd4);
        p1_attack = 1'b0;

        // Wear p2 down to 1.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(30);
            p1_attack = 1'b1;
            applyStimulus(1);
            checkOutput("wear_down", 10'(p2_health), 10'(3 - i));
            p1_attack = 1'b0;
        end

        // Final blow.
        applyStimulus(30);
        p1_attack = 1'b1;
        applyStimulus(1);
        checkAll("final_blow", 4'd9, 4'd0, 1'b0, 1'b1, 1'b1, 2'b01);
        p1_attack = 1'b0;
        applyStimulus(30);
        // p2 attack in OVER is ignored.
        p2_attack = 1'b1;
        applyStimulus(1);
        checkAll("over_ignored", 4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
        p2_attack = 1'b0;
        applyStimulus(1);

        // Restart.
        round_start = 1'b1;
        applyStimulus(1);
        round_start = 1'b0;
        checkAll("restart", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);

        // Draw: nine simultaneous hits.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(30);
            p1_attack = 1'b1;
            p2_attack = 1'b1;
            applyStimulus(1);
            checkOutput("draw_p1_step", 10'(p1_health), 10'(8 - i));
            checkOutput("draw_p2_step", 10'(p2_health), 10'(8 - i));
            p1_attack = 1'b0;
            p2_attack = 1'b0;
        end
        applyStimulus(30);
        p1_attack = 1'b1;
        p2_attack = 1'b1;
        applyStimulus(1);
        checkAll("draw", 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 2'b11);
        p1_attack = 1'b0;
        p2_attack = 1'b0;

        // Async reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_reset", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(1);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
